bus_load_unit: RTL and testbench
================================

Name: bus_load_unit

Overview:
- Receiving end of the shared 16-bit internal bus.
- Elsewhere, a source enables its tri-state transfer driver and asserts bus_valid. This block accepts a burst of words from the bus into a small local register file at consecutive addresses.
- Flags are updated per accepted word, and a registered read port is provided.
- Used by the stack CPU to bulk-load operands/frames from the bus under a start/busy/done handshake.

Parameters:
- WIDTH, 16, bus and register data width
- NREG, 8, number of local registers (power of two)
- AW, 3, address width, log2(NREG)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- bus_in  input  WIDTH  shared bus data (valid only while bus_valid=1)
- bus_valid  input  1  a bus driver is presenting a word this cycle
- bus_ready  output  1  block will accept the word on this edge
- start  input  1  begin burst (sampled only in IDLE)
- base_addr  input  AW  first destination register
- count  input  4  words in burst, 0..15
- abort  input  1  terminate burst without done
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at normal burst completion
- rd_addr  input  AW  read address
- rd_data  output  WIDTH  registered read data
- flags_out  output  4  {W,P,N,Z} of last accepted word

Behaviour:
- Reset (synchronous, highest priority): all registers 0, state IDLE, bus_ready=0, busy=0, done=0, flags_out=0, rd_data=0, ptr=0, remaining=0.
- States: IDLE, LOAD, DONE. All outputs are registered.
- IDLE, start=1, count!=0:
  - next cycle: LOAD, busy=1, bus_ready=1
  - ptr=base_addr, remaining=count, W flag cleared (other flags held)
- IDLE, start=1, count=0: next cycle DONE (done=1 for one cycle); busy stays 0; no bus_ready.
- LOAD accept: when bus_valid=1 and bus_ready=1 at the edge:
  - regs[ptr]<=bus_in
  - ptr<=ptr+1 mod NREG
  - remaining<=remaining-1
  - Z<=(bus_in==0), N<=bus_in[WIDTH-1], P<=^bus_in (odd parity)
  - W<=1 if ptr==NREG-1 at this accept (sticky until next start)
- LOAD with bus_valid=0: nothing changes; bus_ready stays 1. There is no timeout.
- Last word (remaining==1 at accept): next cycle DONE, bus_ready=0, busy=0, done=1. Back-to-back accepts at one word per cycle are supported.
- DONE lasts exactly one cycle, then IDLE. start in DONE is ignored; it must be re-asserted in IDLE.
- count>NREG: writes wrap and overwrite earlier words of the same burst; W=1.
- abort in LOAD: next cycle IDLE, busy=0, bus_ready=0, no done pulse.
  - A word accepted on the same edge as abort is still written and updates flags.
  - abort outside LOAD is ignored.
- start while LOAD or DONE: ignored.
- Read port:
  - rd_data<=regs[rd_addr] every cycle, one-cycle latency, independent of state.
  - Same-edge read and write of one address returns the old value (read-before-write).
- Reset mid-burst: immediate return to IDLE, register contents cleared, no done.
- bus_in is sampled only on accept; X/Z on bus_in when bus_valid=0 must not affect any state.

Test Plan:
- Reset, then start base=2 count=3 with bus_valid held 1 and words 0x1234, 0x0000, 0x8001 -> three accepts on consecutive edges.
  - regs[2..4] = 0x1234, 0x0000, 0x8001
  - done pulses exactly once, 1 cycle after the last accept
  - final flags_out = {W0,P0,N1,Z0}
- start base=6 count=4, words 0xA..0xD -> regs6=A, regs7=B, regs0=C, regs1=D; W=1.
  - Follow-up burst base=0 count=1 with word 0x0000 -> W=0, Z=1.
- Burst count=2 with bus_valid gapped (1,0,0,1) -> only two writes; bus_ready held 1 through the gaps; done after the 2nd accept.
- start count=0 -> done pulses 1 cycle later, busy never 1, no register changes.
- Burst count=5: abort asserted on the edge of the 2nd accept.
  - both words written
  - busy=0 and bus_ready=0 next cycle
  - no done; a 3rd bus_valid is not accepted
- Reset asserted mid-burst, then rd_addr sweep 0..7 -> rd_data=0 for all; same-edge write/read of addr 3 -> rd_data shows the old value, then the new value one cycle later.

Source files
------------

// File: rtl/bus_load_unit.sv
// Bus load unit: accepts a burst of bus words into a local register file.
// Start/busy/done handshake, per-word flags, registered read port.
module bus_load_unit #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             bus_valid,
    output logic             bus_ready,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [3:0]       count,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [3:0]       flags_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [3:0]       rem_q, rem_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             accept;

    // bus_in is only looked at on an accept, so X on an idle bus is harmless
    assign accept = ready_q && bus_valid;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        flags_d = flags_q;
        regs_d  = regs_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != 4'd0) begin
                        state_d    = S_LOAD;
                        ptr_d      = base_addr;
                        rem_d      = count;
                        flags_d[3] = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    regs_d[ptr_q] = bus_in;
                    ptr_d         = ptr_q + 1'b1;
                    rem_d         = rem_q - 4'd1;
                    flags_d[0]    = (bus_in == '0);
                    flags_d[1]    = bus_in[WIDTH-1];
                    flags_d[2]    = ^bus_in;
                    if (ptr_q == AW'(NREG - 1)) flags_d[3] = 1'b1;
                    if (rem_q == 4'd1) state_d = S_DONE;
                end
                // abort wins over completion on the same edge
                if (abort) state_d = S_IDLE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d    = (state_d == S_LOAD);
        ready_d   = (state_d == S_LOAD);
        done_d    = (state_d == S_DONE);
        rd_data_d = regs_q[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            flags_q   <= '0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            flags_q   <= flags_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            regs_q    <= regs_d;
        end
    end

    assign bus_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign flags_out = flags_q;

endmodule

// File: tb/tb_bus_load_unit.sv
// Directed self-checking bench for bus_load_unit.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_bus_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic        bus_valid;
    logic        bus_ready;
    logic        start;
    logic [2:0]  base_addr;
    logic [3:0]  count;
    logic        abort;
    logic        busy;
    logic        done;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  flags_out;

    int checks = 0;
    int errors = 0;
    logic [15:0] wq [16];

    bus_load_unit dut (
        .clk       (clk),
        .reset     (reset),
        .bus_in    (bus_in),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .flags_out (flags_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input logic [2:0] a, input logic [15:0] exp,
                             input string tag);
        rd_addr = a;
        step();
        chk(tag, rd_data, exp);
    endtask

    // back-to-back burst of n words from wq, done expected after last accept
    task automatic burst(input logic [2:0] b, input logic [3:0] n,
                         input string tag);
        start = 1'b1;
        base_addr = b;
        count = n;
        step();
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_ready"}, bus_ready, 1);
        for (int i = 0; i < int'(n); i++) begin
            bus_valid = 1'b1;
            bus_in = wq[i];
            step();
        end
        bus_valid = 1'b0;
        bus_in = 'x;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_ready_end"}, bus_ready, 0);
        step();
        chk({tag, "_done_once"}, done, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus_in = '0;
        bus_valid = 1'b0;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        abort = 1'b0;
        rd_addr = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", flags_out, 0);
        chk("rst_rd", rd_data, 0);
        reset = 1'b0;
        step();

        // burst 1: base 2, three words
        wq[0] = 16'h1234;
        wq[1] = 16'h0000;
        wq[2] = 16'h8001;
        burst(3'd2, 4'd3, "b1");
        chk("b1_flags", flags_out, 4'b0010);
        check_reg(3'd2, 16'h1234, "b1_r2");
        check_reg(3'd3, 16'h0000, "b1_r3");
        check_reg(3'd4, 16'h8001, "b1_r4");

        // burst 2: wraps from 7 to 0
        wq[0] = 16'h000A;
        wq[1] = 16'h000B;
        wq[2] = 16'h000C;
        wq[3] = 16'h000D;
        burst(3'd6, 4'd4, "b2");
        chk("b2_flags", flags_out, 4'b1100);
        check_reg(3'd6, 16'h000A, "b2_r6");
        check_reg(3'd7, 16'h000B, "b2_r7");
        check_reg(3'd0, 16'h000C, "b2_r0");
        check_reg(3'd1, 16'h000D, "b2_r1");

        // follow-up single zero word clears W
        wq[0] = 16'h0000;
        burst(3'd0, 4'd1, "b3");
        chk("b3_flags", flags_out, 4'b0001);
        check_reg(3'd0, 16'h0000, "b3_r0");

        // gapped valid 1,0,0,1
        start = 1'b1;
        base_addr = 3'd5;
        count = 4'd2;
        step();
        start = 1'b0;
        bus_valid = 1'b1;
        bus_in = 16'h1111;
        step();
        bus_valid = 1'b0;
        bus_in = 'x;
        chk("gap_ready1", bus_ready, 1);
        step();
        chk("gap_ready2", bus_ready, 1);
        chk("gap_nodone", done, 0);
        step();
        bus_valid = 1'b1;
        bus_in = 16'h2222;
        step();
        bus_valid = 1'b0;
        bus_in = 'x;
        chk("gap_done", done, 1);
        step();
        chk("gap_flags", flags_out, 4'b0000);
        check_reg(3'd5, 16'h1111, "gap_r5");
        check_reg(3'd6, 16'h2222, "gap_r6");
        check_reg(3'd7, 16'h000B, "gap_r7");

        // count = 0
        start = 1'b1;
        base_addr = 3'd2;
        count = 4'd0;
        step();
        start = 1'b0;
        chk("c0_done", done, 1);
        chk("c0_busy", busy, 0);
        chk("c0_ready", bus_ready, 0);
        step();
        chk("c0_done_end", done, 0);
        chk("c0_busy_end", busy, 0);
        check_reg(3'd2, 16'h1234, "c0_r2");

        // abort on the second accept
        start = 1'b1;
        base_addr = 3'd0;
        count = 4'd5;
        step();
        start = 1'b0;
        bus_valid = 1'b1;
        bus_in = 16'h0101;
        step();
        bus_in = 16'h0202;
        abort = 1'b1;
        step();
        abort = 1'b0;
        bus_in = 16'h0303;
        chk("ab_busy", busy, 0);
        chk("ab_ready", bus_ready, 0);
        chk("ab_nodone", done, 0);
        step();
        bus_valid = 1'b0;
        bus_in = 'x;
        chk("ab_nodone2", done, 0);
        chk("ab_busy2", busy, 0);
        chk("ab_flags", flags_out, 4'b0000);
        check_reg(3'd0, 16'h0101, "ab_r0");
        check_reg(3'd1, 16'h0202, "ab_r1");
        check_reg(3'd2, 16'h1234, "ab_r2");

        // reset mid-burst
        start = 1'b1;
        base_addr = 3'd3;
        count = 4'd4;
        step();
        start = 1'b0;
        bus_valid = 1'b1;
        bus_in = 16'hFFFF;
        step();
        bus_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_ready", bus_ready, 0);
        chk("mr_done", done, 0);
        chk("mr_flags", flags_out, 0);
        for (int a = 0; a < 8; a++) begin
            check_reg(3'(a), 16'h0000, $sformatf("mr_r%0d", a));
        end
        chk("mr_nodone", done, 0);

        // same-edge write and read of address 3
        start = 1'b1;
        base_addr = 3'd3;
        count = 4'd1;
        step();
        start = 1'b0;
        bus_valid = 1'b1;
        bus_in = 16'hBEEF;
        rd_addr = 3'd3;
        step();
        bus_valid = 1'b0;
        bus_in = 'x;
        chk("rbw_old", rd_data, 16'h0000);
        chk("rbw_done", done, 1);
        step();
        chk("rbw_new", rd_data, 16'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
